pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter LEN, default 8: duty width in bits; PWM period is 2^LEN clocks.
REQ-002 Parameter STEP, default 1: duty change per ramp step, range 1..2^LEN-1.
REQ-003 Parameter DIV, default 1: PWM periods per ramp step, range 1..255.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 tgt_val  input  LEN  requested target duty.
REQ-007 tgt_valid  input  1  target request valid.
REQ-008 tgt_ready  output  1  target accepted when tgt_valid & tgt_ready at rising edge.
REQ-009 abort  input  1  freeze ramp at current duty.
REQ-010 val  output  LEN  registered duty value driving the pwm generator.
REQ-011 period_start  output  1  registered one-cycle pulse marking the first clock of each PWM period.
REQ-012 busy  output  1  high while ramping.
REQ-013 done  output  1  registered one-cycle pulse when val reaches target.

Function
REQ-014 Internal period counter cnt (LEN bits) SHALL increment every clock and wrap 2^LEN-1 -> 0.
REQ-015 "Boundary edge" = the rising edge where cnt goes 2^LEN-1 -> 0; period_start SHALL be 1 in exactly the cycle following each boundary edge.
REQ-016 FSM states IDLE, UP, DOWN; tgt_ready = 1 only in IDLE; busy = 1 only in UP/DOWN.
REQ-017 IDLE accept: target register <= tgt_val, step divider div_cnt <= 0; next state UP if tgt_val > val, DOWN if tgt_val < val, else stay IDLE and pulse done next cycle.
REQ-018 tgt_valid outside IDLE SHALL be ignored (no latch, no state change).
REQ-019 val SHALL change only on boundary edges while in UP/DOWN, never mid-period.
REQ-020 In UP/DOWN at each boundary edge: if div_cnt == DIV-1, apply step and clear div_cnt, else increment div_cnt.
REQ-021 UP step: val <= min(val+STEP, target), sum computed in LEN+1 bits, no wrap.
REQ-022 DOWN step: val <= max(val-STEP, target), underflow detected via LEN+1-bit difference, no wrap.
REQ-023 When the stepped val equals target, FSM SHALL enter IDLE on the same edge and done SHALL be 1 in the following cycle only.
REQ-024 Latency: with DIV=1, first change of val occurs on the first boundary edge strictly after the accept edge; an accept coinciding with a boundary edge SHALL NOT step on that edge.
REQ-025 abort=1 in UP/DOWN: target <= val, state <= IDLE on that edge, done not pulsed; abort has priority over a coincident step. abort in IDLE has no effect.

Reset
REQ-026 rst low SHALL immediately force: cnt=0, div_cnt=0, target=0, val=0, state IDLE, tgt_ready=1, busy=0, done=0, period_start=0.
REQ-027 After rst release, first period_start pulse SHALL occur 2^LEN clocks later (cycle after cnt wraps); reset mid-ramp aborts the ramp with no done pulse.

Verification (LEN=8, STEP=16, DIV=1 unless stated)
REQ-028 Reset release -> val=0, tgt_ready=1, busy=0; period_start pulses every 256 clocks.
REQ-029 Accept 64 from val=0 -> val 16,32,48,64 on four successive boundaries, unchanged between; done one cycle after 64; tgt_ready=1 again.
REQ-030 From 64 accept 30 -> val 48,32,30 (clamped); tgt_valid=1 with 200 while busy -> ignored, final val=30.
REQ-031 STEP=32, val=240, target 255 -> single step to 255, no wrap to 16; DIV=3 case -> steps every third boundary only.
REQ-032 Abort mid-ramp at val=32 (target 128) -> val holds 32, IDLE, no done; rst low mid-ramp -> val=0 asynchronously, busy=0.
REQ-033 Accept on a boundary edge -> no step that edge; tgt_val equal to val -> done pulse, stays IDLE, busy never 1.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Ramps a registered PWM duty value toward a requested target. The duty
//   only moves on PWM period boundaries, by STEP per move and at most once
//   every DIV periods, and it is clamped at the target so it never overshoots
//   or wraps.
//
// Parameters
//   LEN   duty width in bits; the PWM period is 2^LEN clocks
//   STEP  duty change per ramp step (1 .. 2^LEN-1)
//   DIV   PWM periods per ramp step (1 .. 255)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   tgt_val      requested target duty
//   tgt_valid    target request valid
//   tgt_ready    high in IDLE; a request is taken when tgt_valid & tgt_ready
//   abort        freeze the ramp at the current duty (ignored in IDLE)
//   val          registered duty value for the PWM generator
//   period_start one-cycle pulse in the first clock of each PWM period
//   busy         high while ramping
//   done         one-cycle pulse after val reaches the target
module pwm_ramp_ctrl #(
  parameter int LEN  = 8,
  parameter int STEP = 1,
  parameter int DIV  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] tgt_val,
  input  logic           tgt_valid,
  output logic           tgt_ready,
  input  logic           abort,
  output logic [LEN-1:0] val,
  output logic           period_start,
  output logic           busy,
  output logic           done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam logic [LEN:0] STEP_X   = (LEN+1)'(STEP);
  localparam logic [7:0]   DIV_LAST = 8'(DIV - 1);

  // Upward step, saturated at the target; the sum carries one extra bit so
  // a large STEP near full scale cannot wrap.
  function automatic logic [LEN-1:0] step_up(input logic [LEN-1:0] cur,
                                             input logic [LEN-1:0] tgt);
    logic [LEN:0] sum;
    sum = {1'b0, cur} + STEP_X;
    if (sum >= {1'b0, tgt}) return tgt;
    return sum[LEN-1:0];
  endfunction

  // Downward step, saturated at the target; a negative signed difference
  // marks underflow below zero.
  function automatic logic [LEN-1:0] step_down(input logic [LEN-1:0] cur,
                                               input logic [LEN-1:0] tgt);
    logic signed [LEN:0] diff;
    diff = $signed({1'b0, cur}) - $signed(STEP_X);
    if (diff <= $signed({1'b0, tgt})) return tgt;
    return diff[LEN-1:0];
  endfunction

  logic [1:0]     state;
  logic [LEN-1:0] cnt;
  logic [LEN-1:0] target;
  logic [7:0]     div_cnt;
  logic [LEN-1:0] val_step;
  logic           boundary;

  // The edge that wraps cnt from all-ones back to zero is the period boundary.
  assign boundary  = &cnt;
  assign tgt_ready = (state == IDLE);
  assign busy      = (state == UP) || (state == DOWN);
  assign val_step  = (state == UP) ? step_up(val, target) : step_down(val, target);

  // Period counter and boundary pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      period_start <= boundary;
    end
  end

  // Ramp control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      target  <= '0;
      val     <= '0;
      div_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // An accept never steps on its own edge, even on a boundary.
          if (tgt_valid) begin
            target  <= tgt_val;
            div_cnt <= '0;
            if (tgt_val > val)      state <= UP;
            else if (tgt_val < val) state <= DOWN;
            else                    done  <= 1'b1;
          end
        end
        UP, DOWN: begin
          // Abort wins over a coincident step and ends the ramp silently.
          if (abort) begin
            target <= val;
            state  <= IDLE;
          end else if (boundary) begin
            if (div_cnt == DIV_LAST) begin
              val     <= val_step;
              div_cnt <= '0;
              if (val_step == target) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl. Instance u0 (STEP=16, DIV=1) is checked by a
// scoreboard of expected val changes and done pulses; u1 (STEP=32) and
// u2 (STEP=16, DIV=3) cover the saturation and divider cases directly.
module tb_pwm_ramp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tv0, tv1, tv2;
  logic       tvl0, tvl1, tvl2;
  logic       ab0, ab1, ab2;
  logic       rdy0, rdy1, rdy2;
  logic [7:0] val0, val1, val2;
  logic       ps0, ps1, ps2;
  logic       busy0, busy1, busy2;
  logic       d0, d1, d2;

  pwm_ramp_ctrl #(.LEN(8), .STEP(16), .DIV(1)) u0 (
    .clk(clk), .rst(rst), .tgt_val(tv0), .tgt_valid(tvl0), .tgt_ready(rdy0),
    .abort(ab0), .val(val0), .period_start(ps0), .busy(busy0), .done(d0));

  pwm_ramp_ctrl #(.LEN(8), .STEP(32), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .tgt_val(tv1), .tgt_valid(tvl1), .tgt_ready(rdy1),
    .abort(ab1), .val(val1), .period_start(ps1), .busy(busy1), .done(d1));

  pwm_ramp_ctrl #(.LEN(8), .STEP(16), .DIV(3)) u2 (
    .clk(clk), .rst(rst), .tgt_val(tv2), .tgt_valid(tvl2), .tgt_ready(rdy2),
    .abort(ab2), .val(val2), .period_start(ps2), .busy(busy2), .done(d2));

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] sb[$];      // {kind, value}: kind 0 = val change, 1 = done pulse
  logic       mon_en = 1'b0;
  logic [7:0] prev_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [8:0] got);
    logic [8:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected event kind=%0d val=%0d, expected none", name, got[8], got[7:0]);
    end else begin
      e = sb.pop_front();
      check(name, 32'(got), 32'(e));
    end
  endtask

  task automatic exp_val(input logic [7:0] v);
    sb.push_back({1'b0, v});
  endtask

  task automatic exp_done(input logic [7:0] v);
    sb.push_back({1'b1, v});
  endtask

  // Monitor: every val change and every done pulse of u0 consumes one entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (val0 !== prev_val) begin
        if (rst) check("val_change_on_boundary", 32'(ps0), 32'd1);
        sb_pop("val_event", {1'b0, val0});
        prev_val = val0;
      end
      if (d0 === 1'b1) sb_pop("done_event", {1'b1, val0});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept0(input logic [7:0] v);
    tv0  = v;
    tvl0 = 1'b1;
    tick(1);
    tvl0 = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (d0) seen = 1;
    end
    if (!seen) check(name, 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic wait_val0(input logic [7:0] v, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (val0 == v) seen = 1;
    end
    if (!seen) check(name, 32'(val0), 32'(v));
  endtask

  task automatic sync_period(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ps0) seen = 1;
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  bz;
    logic [7:0] exp2 [6];
    exp2[0] = 8'd0;  exp2[1] = 8'd0;  exp2[2] = 8'd16;
    exp2[3] = 8'd16; exp2[4] = 8'd16; exp2[5] = 8'd32;

    tv0 = '0; tv1 = '0; tv2 = '0;
    tvl0 = 0; tvl1 = 0; tvl2 = 0;
    ab0 = 0; ab1 = 0; ab2 = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    check("rst_val", 32'(val0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(d0), 32'd0);
    check("rst_period_start", 32'(ps0), 32'd0);

    @(negedge clk);
    rst      = 1'b1;
    prev_val = val0;
    mon_en   = 1'b1;

    // First period_start 256 clocks after release, then every 256 clocks.
    for (int k = 0; k < 2; k++) begin
      n = 0;
      seen = 0;
      while (!seen && n < 600) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (ps0) seen = 1;
      end
      check(k == 0 ? "first_period_start" : "period_interval", 32'(n), 32'd256);
    end
    tick(10);

    // Ramp 0 -> 64.
    exp_val(16); exp_val(32); exp_val(48); exp_val(64); exp_done(64);
    accept0(64);
    check("busy_after_accept", 32'(busy0), 32'd1);
    wait_done0("timeout_ramp_64");
    check("ready_after_64", 32'(rdy0), 32'd1);
    check("busy_after_64", 32'(busy0), 32'd0);
    check("val_64", 32'(val0), 32'd64);

    // Ramp 64 -> 30 with a clamped last step; a request while busy is ignored.
    exp_val(48); exp_val(32); exp_val(30); exp_done(30);
    accept0(30);
    tick(3);
    tv0 = 200;
    tvl0 = 1'b1;
    tick(20);
    check("ready_while_busy", 32'(rdy0), 32'd0);
    tvl0 = 1'b0;
    wait_done0("timeout_ramp_30");
    check("val_30", 32'(val0), 32'd30);

    // 30 -> 0 clamps at zero, then 0 -> 128 aborted at 32.
    exp_val(14); exp_val(0); exp_done(0);
    accept0(0);
    wait_done0("timeout_ramp_0");
    exp_val(16); exp_val(32);
    accept0(128);
    wait_val0(32, "timeout_val_32");
    tick(5);
    ab0 = 1'b1;
    tick(1);
    ab0 = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_ready", 32'(rdy0), 32'd1);
    tick(600);
    check("abort_val_hold", 32'(val0), 32'd32);

    // Accept exactly on a boundary edge: no step on that edge.
    sync_period("timeout_sync_boundary");
    repeat (255) @(posedge clk);
    #1;
    exp_val(48); exp_done(48);
    accept0(48);
    check("boundary_accept_ps", 32'(ps0), 32'd1);
    check("boundary_accept_val", 32'(val0), 32'd32);
    n = 0;
    while (val0 == 8'd32 && n < 600) begin
      tick(1);
      n++;
    end
    check("boundary_accept_latency", 32'(n), 32'd256);
    wait_done0("timeout_ramp_48");

    // Target equal to current duty: done pulse only.
    exp_done(48);
    accept0(48);
    bz = 0;
    repeat (8) begin
      if (busy0) bz = 1;
      tick(1);
    end
    check("equal_busy_never", 32'(bz), 32'd0);
    check("equal_ready", 32'(rdy0), 32'd1);

    // STEP=32: 0 -> 240, then 240 -> 255 in one saturated step.
    tv1 = 240; tvl1 = 1'b1; tick(1); tvl1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (d1) seen = 1;
    end
    check("u1_done_240", 32'(seen), 32'd1);
    check("u1_val_240", 32'(val1), 32'd240);
    tick(1);
    tv1 = 255; tvl1 = 1'b1; tick(1); tvl1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (d1) seen = 1;
    end
    check("u1_done_255", 32'(seen), 32'd1);
    check("u1_val_255", 32'(val1), 32'd255);
    check("u1_ready", 32'(rdy1), 32'd1);
    check("u1_busy", 32'(busy1), 32'd0);
    check("u1_ps_aligned", 32'(ps1), 32'(ps0));
    tick(1);

    // DIV=3: 0 -> 32 steps only on every third boundary.
    sync_period("timeout_sync_div");
    tick(5);
    tv2 = 32; tvl2 = 1'b1; tick(1); tvl2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (ps2) seen = 1;
      end
      check($sformatf("u2_boundary_%0d", k + 1), 32'(val2), 32'(exp2[k]));
    end
    check("u2_done", 32'(d2), 32'd1);
    tick(2);
    check("u2_ready", 32'(rdy2), 32'd1);
    check("u2_busy", 32'(busy2), 32'd0);

    // Reset in the middle of a ramp: immediate clear, no done.
    exp_val(64);
    accept0(200);
    wait_val0(64, "timeout_val_64");
    tick(20);
    #2;
    exp_val(0);
    rst = 1'b0;
    #1;
    check("async_rst_val", 32'(val0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_ready", 32'(rdy0), 32'd1);
    tick(3);
    @(negedge clk);
    rst = 1'b1;
    tick(300);
    check("post_rst_val", 32'(val0), 32'd0);
    check("post_rst_busy", 32'(busy0), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
